grey_frame_seq: RTL and testbench
=================================

Name: grey_frame_seq

Overview:
Frame/line sequencer placed in front of the 2x2 greyscale averaging datapath. It receives the raw sensor stream (frame-valid, data-valid) and generates the X/Y coordinates and gated data-valid that the datapath consumes. It also issues a keep strobe that selects one output per 2x2 Bayer quad. It arms and stops capture on command and reports frame completion, frame count and geometry errors.

Parameters:
LINE_W, 1280, active pixels per line; must match the datapath line-buffer depth.
FRAME_H, 960, active lines per frame.
CW, 11, coordinate counter width; oX_Cont/oY_Cont width.
FCW, 16, frame counter width.

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous active-high reset
iStart  in  1  one-cycle pulse; arm capture for the next frame
iStop  in  1  one-cycle pulse; stop after the current frame
iFVAL  in  1  sensor frame valid
iDVAL  in  1  sensor pixel valid
oX_Cont  out  CW  pixel column to datapath
oY_Cont  out  CW  line index to datapath
oDVAL  out  1  gated pixel valid to datapath
oKeep  out  1  high when datapath output is a complete 2x2 average (odd X and odd Y)
oBusy  out  1  high in ARMED, ACTIVE and DRAIN
oFrame_Done  out  1  one-cycle pulse at clean end of frame
oFrame_Cnt  out  FCW  count of completed frames, wraps
oErr  out  1  sticky geometry error; cleared by iStart or iRST

Behaviour:
- All outputs are registered. Reset value is 0 for all outputs. State returns to IDLE.
- States and transitions:
  - IDLE to ARMED on iStart.
  - ARMED to ACTIVE on the rising edge of iFVAL (iFVAL=1 with the previous sample 0). A frame already in progress when arming is skipped.
  - ACTIVE to DRAIN when the last pixel is accepted, that is iDVAL with X=LINE_W-1 and Y=FRAME_H-1.
  - ACTIVE to DRAIN also when iFVAL falls early. This sets oErr.
  - DRAIN lasts one cycle. It pulses oFrame_Done only on a clean end, and increments oFrame_Cnt only on a clean end.
  - DRAIN to ARMED if no stop is pending; DRAIN to IDLE if a stop is pending.
- iStop in ARMED returns to IDLE on the next cycle. iStop in ACTIVE sets stop_pending. iStop in IDLE is ignored.
- iStart and iStop in the same cycle: iStop wins. iStart in a non-IDLE state only clears oErr.
- Counters advance only in ACTIVE on iDVAL.
  - X increments by 1. At LINE_W-1, X wraps to 0 and Y increments.
  - Y saturates at FRAME_H-1. Extra iDVAL beyond the frame set oErr and are not forwarded.
- Line length check: if iFVAL falls while X is not 0 (partial line), set oErr.
- Output timing: oDVAL, oX_Cont and oY_Cont appear 1 cycle after the accepted iDVAL. They carry the coordinate of that pixel, so they stay aligned with the datapath's registered data.
  - oDVAL=0 outside ACTIVE. oX_Cont and oY_Cont hold their last values when oDVAL=0.
  - oKeep = oDVAL & oX_Cont[0] & oY_Cont[0].
- Line 0 primes the datapath line buffer. oKeep is never high on Y=0. No separate wait is required.
- iRST mid-frame: immediate IDLE, counters cleared, no oFrame_Done pulse. Any remaining frame is ignored until the next iStart and the next iFVAL rising edge.
- oFrame_Cnt wraps from 2^FCW-1 to 0 with no flag.

Optional Feature:
GREY_SEQ_CROP_EN.
- Defined: adds ports iCrop_X0, iCrop_Y0, iCrop_W and iCrop_H (each CW wide), sampled on iStart.
  - oDVAL is asserted only for pixels inside the window.
  - oX_Cont and oY_Cont are window-relative, starting at 0.
  - oKeep parity is computed on the relative coordinates.
  - Frame geometry checks still use LINE_W/FRAME_H.
  - A window that extends past the frame is clipped to the frame.
- Undefined: ports absent; full frame forwarded.

Decomposition:
- Package grey_pkg holds:
  - typedef enum logic [2:0] seq_state_t {IDLE, ARMED, ACTIVE, DRAIN}
  - default constants LINE_W_DEF=1280, FRAME_H_DEF=960
  - typedef coord_t = logic [10:0]
- One sub-module, grey_xy_counter: a wrapping X/Y counter with enable, clear, last-pixel flag and saturate. It is reused if a crop-relative counter is needed.

Test Plan:
- Clean frame (LINE_W=8, FRAME_H=4): iStart, iFVAL rise, 32 iDVAL.
  - 32 oDVAL with coordinates (0,0)..(7,3), each one cycle after its iDVAL.
  - 8 oKeep, at odd X on Y=1 and Y=3.
  - oFrame_Done 1 pulse, oFrame_Cnt=1, oErr=0.
- Short frame: iFVAL falls after 20 pixels.
  - oErr=1, no oFrame_Done, oFrame_Cnt unchanged.
  - Returns to ARMED; the next clean frame counts, and oErr stays set until iStart.
- Late arm: iStart mid-frame.
  - Current frame ignored (oDVAL=0).
  - Capture begins at the next iFVAL rising edge.
- Stop during ACTIVE: iStop at pixel 10.
  - Frame completes, oFrame_Done pulses, state IDLE, oBusy=0.
  - A following frame produces no oDVAL.
- Reset mid-frame: iRST at pixel 15.
  - Next cycle: all outputs 0, state IDLE.
  - Remaining iDVAL are ignored.
- iStart and iStop in the same cycle from IDLE: state remains IDLE, oBusy=0.

Source files
------------

// File: rtl/grey_pkg.sv
// grey_pkg: shared state type, default geometry and helpers for the greyscale frame sequencer.
package grey_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ACTIVE,
        DRAIN
    } seq_state_t;

    localparam int LINE_W_DEF  = 1280;
    localparam int FRAME_H_DEF = 960;

    typedef logic [10:0] coord_t;

    // One output per 2x2 quad: only the bottom-right pixel carries a complete average.
    function automatic logic keep_sel(input logic dval, input logic x_lsb, input logic y_lsb);
        return dval & x_lsb & y_lsb;
    endfunction

endpackage

// File: rtl/grey_frame_seq_if.sv
// grey_frame_seq_if: sensor-side control/stream inputs and datapath-side outputs of the sequencer.
// With GREY_SEQ_CROP_EN defined the capture-window inputs are added.
interface grey_frame_seq_if #(
    parameter int CW  = 11,
    parameter int FCW = 16
);
    logic           iStart;
    logic           iStop;
    logic           iFVAL;
    logic           iDVAL;
    logic [CW-1:0]  oX_Cont;
    logic [CW-1:0]  oY_Cont;
    logic           oDVAL;
    logic           oKeep;
    logic           oBusy;
    logic           oFrame_Done;
    logic [FCW-1:0] oFrame_Cnt;
    logic           oErr;
`ifdef GREY_SEQ_CROP_EN
    logic [CW-1:0]  iCrop_X0;
    logic [CW-1:0]  iCrop_Y0;
    logic [CW-1:0]  iCrop_W;
    logic [CW-1:0]  iCrop_H;

    modport master (
        output iStart, iStop, iFVAL, iDVAL, iCrop_X0, iCrop_Y0, iCrop_W, iCrop_H,
        input  oX_Cont, oY_Cont, oDVAL, oKeep, oBusy, oFrame_Done, oFrame_Cnt, oErr
    );
    modport slave (
        input  iStart, iStop, iFVAL, iDVAL, iCrop_X0, iCrop_Y0, iCrop_W, iCrop_H,
        output oX_Cont, oY_Cont, oDVAL, oKeep, oBusy, oFrame_Done, oFrame_Cnt, oErr
    );
`else
    modport master (
        output iStart, iStop, iFVAL, iDVAL,
        input  oX_Cont, oY_Cont, oDVAL, oKeep, oBusy, oFrame_Done, oFrame_Cnt, oErr
    );
    modport slave (
        input  iStart, iStop, iFVAL, iDVAL,
        output oX_Cont, oY_Cont, oDVAL, oKeep, oBusy, oFrame_Done, oFrame_Cnt, oErr
    );
`endif
endinterface

// File: rtl/grey_xy_counter.sv
// grey_xy_counter: raster X/Y counter; X wraps at line end, both saturate on the last pixel.
module grey_xy_counter #(
    parameter int LINE_W  = 1280,
    parameter int FRAME_H = 960,
    parameter int CW      = 11
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_last
);
    localparam logic [CW-1:0] X_LAST = CW'(LINE_W - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(FRAME_H - 1);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          w_eol;
    logic          w_last;

    assign w_eol  = (r_x == X_LAST);
    assign w_last = w_eol && (r_y == Y_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_en && !w_last) begin
            if (w_eol) begin
                r_x <= '0;
                r_y <= r_y + CW'(1);
            end else begin
                r_x <= r_x + CW'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_last;

endmodule

// File: rtl/grey_frame_seq.sv
// grey_frame_seq: frame/line sequencer ahead of the 2x2 greyscale datapath (macro GREY_SEQ_CROP_EN adds a capture window).
// States: IDLE wait iStart | ARMED wait iFVAL rise | ACTIVE count pixels | DRAIN one-cycle frame wrap-up
module grey_frame_seq
    import grey_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int CW      = 11,
    parameter int FCW     = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    grey_frame_seq_if.slave io_seq
);
    seq_state_t     r_state;
    seq_state_t     w_next_state;

    logic           r_fval_d;
    logic           r_stop_pend;
    logic           r_frame_err;
    logic           r_dval;
    logic           r_keep;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [CW-1:0]  r_x_out;
    logic [CW-1:0]  r_y_out;
    logic [FCW-1:0] r_cnt;

    logic           w_start;
    logic           w_rise;
    logic           w_accept;
    logic           w_early;
    logic           w_extra;
    logic           w_cnt_clr;
    logic [CW-1:0]  w_x;
    logic [CW-1:0]  w_y;
    logic           w_last;
    logic           w_fwd;
    logic [CW-1:0]  w_x_fwd;
    logic [CW-1:0]  w_y_fwd;

    logic           w_dval_nx;
    logic           w_keep_nx;
    logic           w_done_nx;
    logic           w_err_nx;
    logic           w_stop_pend_nx;
    logic           w_frame_err_nx;
    logic [CW-1:0]  w_x_nx;
    logic [CW-1:0]  w_y_nx;
    logic [FCW-1:0] w_cnt_nx;

    // A simultaneous iStop cancels iStart in every state.
    assign w_start   = io_seq.iStart & ~io_seq.iStop;
    assign w_rise    = io_seq.iFVAL & ~r_fval_d;
    assign w_accept  = (r_state == ACTIVE) & io_seq.iFVAL & io_seq.iDVAL;
    assign w_early   = (r_state == ACTIVE) & ~io_seq.iFVAL;
    assign w_extra   = (r_state == DRAIN) & io_seq.iFVAL & io_seq.iDVAL;
    assign w_cnt_clr = (r_state != ACTIVE);

    grey_xy_counter #(
        .LINE_W  (LINE_W),
        .FRAME_H (FRAME_H),
        .CW      (CW)
    ) u_xy (
        .i_clk  (iCLK),
        .i_rst  (iRST),
        .i_clr  (w_cnt_clr),
        .i_en   (w_accept),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_last (w_last)
    );

`ifdef GREY_SEQ_CROP_EN
    logic [CW-1:0] r_cx0;
    logic [CW-1:0] r_cy0;
    logic [CW:0]   r_cx1;
    logic [CW:0]   r_cy1;
    logic          w_in_x;
    logic          w_in_y;

    // Window end is kept one bit wider so X0+W past the frame clips instead of wrapping.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_cx0 <= '0;
            r_cy0 <= '0;
            r_cx1 <= '0;
            r_cy1 <= '0;
        end else if (w_start && (r_state == IDLE)) begin
            r_cx0 <= io_seq.iCrop_X0;
            r_cy0 <= io_seq.iCrop_Y0;
            r_cx1 <= {1'b0, io_seq.iCrop_X0} + {1'b0, io_seq.iCrop_W};
            r_cy1 <= {1'b0, io_seq.iCrop_Y0} + {1'b0, io_seq.iCrop_H};
        end
    end

    assign w_in_x  = (w_x >= r_cx0) && ({1'b0, w_x} < r_cx1);
    assign w_in_y  = (w_y >= r_cy0) && ({1'b0, w_y} < r_cy1);
    assign w_fwd   = w_accept & w_in_x & w_in_y;
    assign w_x_fwd = w_x - r_cx0;
    assign w_y_fwd = w_y - r_cy0;
`else
    assign w_fwd   = w_accept;
    assign w_x_fwd = w_x;
    assign w_y_fwd = w_y;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = ARMED;
                end
            end
            ARMED: begin
                if (io_seq.iStop) begin
                    w_next_state = IDLE;
                end else if (w_rise) begin
                    w_next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_early || (w_accept && w_last)) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_next_state = (r_stop_pend || io_seq.iStop) ? IDLE : ARMED;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_dval_nx      = w_fwd;
        w_x_nx         = w_fwd ? w_x_fwd : r_x_out;
        w_y_nx         = w_fwd ? w_y_fwd : r_y_out;
        w_keep_nx      = keep_sel(w_dval_nx, w_x_nx[0], w_y_nx[0]);
        w_done_nx      = (r_state == DRAIN) & ~r_frame_err;
        w_cnt_nx       = r_cnt + FCW'(w_done_nx);
        w_stop_pend_nx = (r_state == ACTIVE) & (r_stop_pend | io_seq.iStop);
        w_frame_err_nx = (r_state != ARMED) & (r_frame_err | w_early);
        w_err_nx       = r_err;
        if (w_start) begin
            w_err_nx = 1'b0;
        end
        if (w_early || w_extra) begin
            w_err_nx = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_fval_d    <= 1'b0;
            r_stop_pend <= 1'b0;
            r_frame_err <= 1'b0;
            r_dval      <= 1'b0;
            r_keep      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_x_out     <= '0;
            r_y_out     <= '0;
            r_cnt       <= '0;
        end else begin
            r_fval_d    <= io_seq.iFVAL;
            r_stop_pend <= w_stop_pend_nx;
            r_frame_err <= w_frame_err_nx;
            r_dval      <= w_dval_nx;
            r_keep      <= w_keep_nx;
            r_busy      <= (w_next_state != IDLE);
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
            r_x_out     <= w_x_nx;
            r_y_out     <= w_y_nx;
            r_cnt       <= w_cnt_nx;
        end
    end

    assign io_seq.oX_Cont     = r_x_out;
    assign io_seq.oY_Cont     = r_y_out;
    assign io_seq.oDVAL       = r_dval;
    assign io_seq.oKeep       = r_keep;
    assign io_seq.oBusy       = r_busy;
    assign io_seq.oFrame_Done = r_done;
    assign io_seq.oFrame_Cnt  = r_cnt;
    assign io_seq.oErr        = r_err;

endmodule

// File: tb/tb_grey_frame_seq.sv
// tb_grey_frame_seq: directed vector table for clean/short frames plus hand sequences for arm/stop/reset corners.
module tb_grey_frame_seq;
    localparam int LW  = 8;
    localparam int FH  = 4;
    localparam int CW  = 11;
    localparam int FCW = 16;

    typedef struct packed {
        logic           dval;
        logic [CW-1:0]  x;
        logic [CW-1:0]  y;
        logic           keep;
        logic           busy;
        logic           done;
        logic           err;
        logic [FCW-1:0] cnt;
    } obs_t;

    typedef struct {
        logic s;
        logic p;
        logic f;
        logic d;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t_dval  = 0;
    int   t_keep  = 0;
    int   t_done  = 0;
    int   m_x     = 0;
    int   m_y     = 0;
    int   m_cnt   = 0;
    logic m_err   = 1'b0;
    vec_t tbl[$];

    grey_frame_seq_if #(.CW(CW), .FCW(FCW)) seq_if ();

    grey_frame_seq #(
        .LINE_W  (LW),
        .FRAME_H (FH),
        .CW      (CW),
        .FCW     (FCW)
    ) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .io_seq (seq_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t o;
        o.dval = seq_if.oDVAL;
        o.x    = seq_if.oX_Cont;
        o.y    = seq_if.oY_Cont;
        o.keep = seq_if.oKeep;
        o.busy = seq_if.oBusy;
        o.done = seq_if.oFrame_Done;
        o.err  = seq_if.oErr;
        o.cnt  = seq_if.oFrame_Cnt;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample at the following falling edge.
    task automatic cyc(input logic s, input logic p, input logic f, input logic d);
        seq_if.iStart = s;
        seq_if.iStop  = p;
        seq_if.iFVAL  = f;
        seq_if.iDVAL  = d;
        @(negedge clk);
        if (seq_if.oDVAL)       t_dval++;
        if (seq_if.oKeep)       t_keep++;
        if (seq_if.oFrame_Done) t_done++;
    endtask

    task automatic send_pixels(input int n, input int stop_at, input logic fwd);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, (k == stop_at), 1'b1, 1'b1);
            if (fwd)
                check($sformatf("pix%0d", k), {seq_if.oDVAL, seq_if.oX_Cont, seq_if.oY_Cont},
                      {1'b1, CW'(k % LW), CW'(k / LW)});
        end
    endtask

    function automatic void add(input logic s, input logic p, input logic f, input logic d,
                                input logic dv, input int x, input int y, input logic kp,
                                input logic by, input logic dn, input logic er, input int cnt);
        vec_t v;
        v.s        = s;
        v.p        = p;
        v.f        = f;
        v.d        = d;
        v.exp.dval = dv;
        v.exp.x    = x[CW-1:0];
        v.exp.y    = y[CW-1:0];
        v.exp.keep = kp;
        v.exp.busy = by;
        v.exp.done = dn;
        v.exp.err  = er;
        v.exp.cnt  = cnt[FCW-1:0];
        tbl.push_back(v);
    endfunction

    // Frame starting from ARMED with iFVAL low; npix < LW*FH ends with an early iFVAL fall.
    function automatic void add_frame(input int npix);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_x, m_y, 1'b0, 1'b1, 1'b0, m_err, m_cnt);
        for (int k = 0; k < npix; k++) begin
            m_x = k % LW;
            m_y = k / LW;
            add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, m_x, m_y, logic'(m_x[0] & m_y[0]),
                1'b1, 1'b0, m_err, m_cnt);
        end
        if (npix == LW * FH) begin
            m_cnt++;
            add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_x, m_y, 1'b0, 1'b1, 1'b1, m_err, m_cnt);
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_x, m_y, 1'b0, 1'b1, 1'b0, m_err, m_cnt);
        end else begin
            m_err = 1'b1;
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_x, m_y, 1'b0, 1'b1, 1'b0, m_err, m_cnt);
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_x, m_y, 1'b0, 1'b1, 1'b0, m_err, m_cnt);
        end
    endfunction

    initial begin
        seq_if.iStart = 1'b0;
        seq_if.iStop  = 1'b0;
        seq_if.iFVAL  = 1'b0;
        seq_if.iDVAL  = 1'b0;
`ifdef GREY_SEQ_CROP_EN
        seq_if.iCrop_X0 = '0;
        seq_if.iCrop_Y0 = '0;
        seq_if.iCrop_W  = CW'(LW);
        seq_if.iCrop_H  = CW'(FH);
`endif

        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        add_frame(32);
        add_frame(20);
        add_frame(32);
        m_err = 1'b0;
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_x, m_y, 1'b0, 1'b1, 1'b0, 1'b0, m_cnt);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_x, m_y, 1'b0, 1'b0, 1'b0, 1'b0, m_cnt);

        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_outputs", sample(), '0);
        rst = 1'b0;

        t_keep = 0;
        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].f, tbl[i].d);
            check($sformatf("vec%0d", i), sample(), tbl[i].exp);
        end
        check("table_keep_total", t_keep, 8 + 4 + 8);

        // Late arm: iStart while a frame is already running.
        t_dval = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) cyc((k == 4), 1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("late_arm_busy", seq_if.oBusy, 1);
        check("late_arm_skip_dval", t_dval, 0);
        t_dval = 0;
        t_keep = 0;
        t_done = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_pixels(32, -1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("late_arm_done", seq_if.oFrame_Done, 1);
        check("late_arm_cnt", seq_if.oFrame_Cnt, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("late_arm_dval_total", t_dval, 32);
        check("late_arm_keep_total", t_keep, 8);
        check("late_arm_done_total", t_done, 1);

        // Stop mid-frame: frame completes, then sequencer goes idle.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_pixels(32, 10, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("stop_done", seq_if.oFrame_Done, 1);
        check("stop_busy", seq_if.oBusy, 0);
        check("stop_cnt", seq_if.oFrame_Cnt, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        t_dval = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_pixels(32, -1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("stop_no_capture", t_dval, 0);
        check("stop_idle_busy", seq_if.oBusy, 0);

        // Reset at pixel 15 of a captured frame.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_pixels(15, -1, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        check("rst_outputs", sample(), '0);
        t_dval = 0;
        send_pixels(16, -1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_ignore_dval", t_dval, 0);
        check("rst_busy", seq_if.oBusy, 0);

        // iStart with iStop from IDLE: stays idle.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("start_stop_busy", seq_if.oBusy, 0);
        t_dval = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_pixels(4, -1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("start_stop_no_capture", t_dval, 0);
        check("start_stop_idle", seq_if.oBusy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
